// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM two-client arbiter.
package psram_pkg;

    localparam int ADDR_W     = 25;
    localparam int WDATA_W    = 16;
    localparam int RDATA_W    = 18;
    localparam int LEN_W      = 8;
    localparam int CNT_W      = 4;
    localparam int WBURST_DEF = 8;
    localparam int RBURST_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } psram_state_t;

    // Counter value seen while the final beat of a burst is transferring.
    function automatic logic [CNT_W-1:0] last_beat(input int burst);
        return CNT_W'(burst - 1);
    endfunction

endpackage

// File: rtl/psram_rr_pick.sv
// Two-way round-robin selector: a sole requester wins; on a tie the
// client that was not granted last time wins.
module psram_rr_pick
    import psram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    // Pick the winner from the current request pair and grant history.
    always_comb begin
        grant = ~last_grant;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~last_grant;
        endcase
    end

endmodule

// File: rtl/psram_arb.sv
// Arbitrates two clients onto one PSRAM controller port, one burst at a
// time. Write bursts run AW -> W beats -> B response; read bursts run
// AR -> R beats. Only the granted client sees handshakes and pulses.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a command; grants only while psram_ready
// ST_WADDR | m_awvalid held with latched address until m_awready
// ST_WDATA | forwarding WBURST write beats from the granted client
// ST_WRESP | waiting for m_bvalid; pulses done/err to the client
// ST_RADDR | m_arvalid held with latched address until m_arready
// ST_RDATA | forwarding RBURST read beats; done with the last beat
module psram_arb
    import psram_pkg::*;
#(
    parameter int WBURST = WBURST_DEF,
    parameter int RBURST = RBURST_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               psram_ready,

    input  logic               c0_cmd_valid,
    output logic               c0_cmd_ready,
    input  logic               c0_cmd_write,
    input  logic [ADDR_W-1:0]  c0_cmd_addr,
    input  logic [WDATA_W-1:0] c0_wdata,
    input  logic               c0_wvalid,
    output logic               c0_wready,
    output logic [RDATA_W-1:0] c0_rdata,
    output logic               c0_rvalid,
    output logic               c0_done,
    output logic               c0_err,

    input  logic               c1_cmd_valid,
    output logic               c1_cmd_ready,
    input  logic               c1_cmd_write,
    input  logic [ADDR_W-1:0]  c1_cmd_addr,
    input  logic [WDATA_W-1:0] c1_wdata,
    input  logic               c1_wvalid,
    output logic               c1_wready,
    output logic [RDATA_W-1:0] c1_rdata,
    output logic               c1_rvalid,
    output logic               c1_done,
    output logic               c1_err,

    output logic [ADDR_W-1:0]  m_awaddr,
    output logic [LEN_W-1:0]   m_awlen,
    output logic               m_awvalid,
    input  logic               m_awready,
    output logic [WDATA_W-1:0] m_wdata,
    output logic               m_wvalid,
    input  logic               m_wready,
    input  logic               m_bvalid,
    input  logic [1:0]         m_bresp,
    output logic               m_bready,
    output logic [ADDR_W-1:0]  m_araddr,
    output logic [LEN_W-1:0]   m_arlen,
    output logic               m_arvalid,
    input  logic               m_arready,
    input  logic [RDATA_W-1:0] m_rdata,
    input  logic               m_rvalid,
    output logic               m_rready
);

    psram_state_t      state_q, state_d;
    logic              gnt_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              pick;
    logic              idle_open;
    logic              sel_valid;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic              accept;
    logic              sel_wvalid;
    logic              w_beat;
    logic              w_last;
    logic              r_beat;
    logic              r_last;

    psram_rr_pick u_pick (
        .req        ({c1_cmd_valid, c0_cmd_valid}),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    assign idle_open  = (state_q == ST_IDLE) & psram_ready;
    assign sel_valid  = pick ? c1_cmd_valid : c0_cmd_valid;
    assign sel_write  = pick ? c1_cmd_write : c0_cmd_write;
    assign sel_addr   = pick ? c1_cmd_addr  : c0_cmd_addr;
    assign accept     = idle_open & sel_valid;

    assign sel_wvalid = gnt_q ? c1_wvalid : c0_wvalid;
    assign w_beat     = (state_q == ST_WDATA) & sel_wvalid & m_wready;
    assign w_last     = w_beat & (cnt_q == last_beat(WBURST));
    assign r_beat     = (state_q == ST_RDATA) & m_rvalid;
    assign r_last     = r_beat & (cnt_q == last_beat(RBURST));

    // State register; reset drops any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the accepted command and count transferred beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            cnt_q        <= '0;
        end else if (accept) begin
            gnt_q        <= pick;
            last_grant_q <= pick;
            addr_q       <= sel_addr;
            cnt_q        <= '0;
        end else if (w_beat | r_beat) begin
            cnt_q        <= cnt_q + CNT_W'(1);
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)    state_d = sel_write ? ST_WADDR : ST_RADDR;
            ST_WADDR: if (m_awready) state_d = ST_WDATA;
            ST_WDATA: if (w_last)    state_d = ST_WRESP;
            ST_WRESP: if (m_bvalid)  state_d = ST_IDLE;
            ST_RADDR: if (m_arready) state_d = ST_RDATA;
            ST_RDATA: if (r_last)    state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Output decode; everything handshake-related is steered to gnt_q only.
    always_comb begin
        c0_cmd_ready = idle_open & ~pick;
        c1_cmd_ready = idle_open &  pick;
        c0_wready    = 1'b0;
        c1_wready    = 1'b0;
        c0_rdata     = '0;
        c1_rdata     = '0;
        c0_rvalid    = 1'b0;
        c1_rvalid    = 1'b0;
        c0_done      = 1'b0;
        c1_done      = 1'b0;
        c0_err       = 1'b0;
        c1_err       = 1'b0;
        m_awaddr     = addr_q;
        m_awlen      = LEN_W'(WBURST);
        m_awvalid    = 1'b0;
        m_wdata      = gnt_q ? c1_wdata : c0_wdata;
        m_wvalid     = 1'b0;
        m_bready     = 1'b0;
        m_araddr     = addr_q;
        m_arlen      = LEN_W'(RBURST);
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        case (state_q)
            ST_WADDR: m_awvalid = 1'b1;
            ST_WDATA: begin
                m_wvalid  = sel_wvalid;
                c0_wready = ~gnt_q & m_wready;
                c1_wready =  gnt_q & m_wready;
            end
            ST_WRESP: begin
                m_bready = 1'b1;
                c0_done  = ~gnt_q & m_bvalid;
                c1_done  =  gnt_q & m_bvalid;
                c0_err   = ~gnt_q & m_bvalid & (m_bresp != 2'b00);
                c1_err   =  gnt_q & m_bvalid & (m_bresp != 2'b00);
            end
            ST_RADDR: m_arvalid = 1'b1;
            ST_RDATA: begin
                m_rready  = 1'b1;
                c0_rvalid = ~gnt_q & m_rvalid;
                c1_rvalid =  gnt_q & m_rvalid;
                c0_rdata  = gnt_q ? '0 : m_rdata;
                c1_rdata  = gnt_q ? m_rdata : '0;
                c0_done   = ~gnt_q & r_last;
                c1_done   =  gnt_q & r_last;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/psram_arb.md
PSRAM_ARB -- requirements
Module: psram_arb

Interface
REQ-001 Parameter WBURST, default 8, write burst length in beats (1..15); driven on m_awlen.
REQ-002 Parameter RBURST, default 4, read burst length in beats (1..15); driven on m_arlen.
REQ-003 Port: clk  in  1  single system clock, all logic on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: psram_ready  in  1  controller ready; new grants only while high.
REQ-006 Port: cN_cmd_valid / cN_cmd_ready  in / out  1 / 1  client N command handshake (N = 0, 1).
REQ-007 Port: cN_cmd_write  in  1  client N: 1 = write burst, 0 = read burst.
REQ-008 Port: cN_cmd_addr  in  25  client N burst start address.
REQ-009 Port: cN_wdata / cN_wvalid / cN_wready  in / in / out  16 / 1 / 1  client N write data beat.
REQ-010 Port: cN_rdata / cN_rvalid  out / out  18 / 1  client N read data beat; no backpressure.
REQ-011 Port: cN_done / cN_err  out / out  1 / 1  one-cycle pulse at burst end; err = write response nonzero.
REQ-012 Port: m_awaddr / m_awlen / m_awvalid / m_awready  out / out / out / in  25 / 8 / 1 / 1  write address to controller.
REQ-013 Port: m_wdata / m_wvalid / m_wready  out / out / in  16 / 1 / 1  write data to controller.
REQ-014 Port: m_bvalid / m_bresp / m_bready  in / in / out  1 / 2 / 1  write response.
REQ-015 Port: m_araddr / m_arlen / m_arvalid / m_arready  out / out / out / in  25 / 8 / 1 / 1  read address.
REQ-016 Port: m_rdata / m_rvalid / m_rready  in / in / out  18 / 1 / 1  read data.

Function
REQ-017 FSM states IDLE, WADDR, WDATA, WRESP, RADDR, RDATA; one transaction outstanding at a time.
REQ-018 IDLE: cN_cmd_ready = (state==IDLE) & psram_ready & (grant==N), combinational; grant to the sole requester, or if both request, to the client not last granted.
REQ-019 Accept (valid & ready) latches write flag, address, client id; updates last_grant; next state WADDR or RADDR.
REQ-020 WADDR/RADDR: m_awvalid/m_arvalid high from cycle after accept, held with stable address until m_awready/m_arready.
REQ-021 WDATA entered only after AW handshake; m_wdata/m_wvalid muxed from granted client; granted cN_wready = m_wready; beat counted only on m_wvalid & m_wready.
REQ-022 After WBURST beats -> WRESP: m_bready = 1; on m_bvalid pulse cN_done, cN_err = (m_bresp != 0); -> IDLE.
REQ-023 RDATA: m_rready = 1; granted cN_rdata/cN_rvalid = m_rdata/m_rvalid same cycle; RBURST-th beat pulses cN_done with that beat; -> IDLE.
REQ-024 Non-granted client: cmd_ready, wready, rvalid, done, err all 0.
REQ-025 Minimum one IDLE cycle between transactions; command present during done cycle is accepted no earlier than next cycle.
REQ-026 psram_ready deassertion mid-transaction ignored; checked only in IDLE.
REQ-027 Beat counter 4 bits, cleared on each accept.

Reset
REQ-028 Reset: state IDLE, all valid/ready/done/err outputs 0, counter 0, last_grant = 1 (client 0 wins first contest).
REQ-029 Reset mid-burst aborts immediately; no done pulse is generated.

Structure
REQ-030 Shared package psram_pkg holds state enum, address width 25, wdata width 16, rdata width 18, default burst constants.
REQ-031 Single sub-module psram_rr_pick: two-way round-robin selector (req[1:0], last_grant -> grant).

Verification
REQ-032 c0 write @0x0000100, m_awready after 2 cycles, 8 beats -> m_awaddr 0x0000100, m_awlen 8, c0_done with c0_err 0.
REQ-033 c0 write + c1 read same cycle after reset -> c0 granted first, c1 read (m_arlen 4) follows after >=1 IDLE cycle.
REQ-034 Read, m_rdata 0x3FFFF..0x00003 four beats -> c1_rdata/c1_rvalid match each beat, c1_done on 4th, c0_rvalid stays 0.
REQ-035 m_wvalid gaps (c0_wvalid toggling) -> exactly 8 beats counted, WRESP entered after 8th; m_bresp=2 -> c0_err 1.
REQ-036 psram_ready=0 with requests -> no cmd_ready; reset asserted in WDATA -> all outputs 0 next cycle, no done.
